// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RV64M iterative multiply/divide unit.
// funct3 selectors, FSM states and iteration counts.
package muldiv_unit_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   localparam int unsigned N_64 = 64;
   localparam int unsigned N_32 = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_SPECIAL,
      ST_DONE
   } state_e;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// subtract the divisor if it fits, report the quotient bit.
module div_step #(
   parameter int W = 64
) (
   input  logic [W:0]   rem_i,
   input  logic [W-1:0] div_i,
   input  logic         bit_i,
   output logic [W:0]   rem_o,
   output logic         q_o
);

   logic [W:0] trial;

   assign trial = {rem_i[W-1:0], bit_i};
   assign q_o   = rem_i[W] | (trial >= {1'b0, div_i});
   assign rem_o = q_o ? (trial - {1'b0, div_i}) : trial;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      func,
   input  logic            sel_32b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] s
);

   import muldiv_unit_pkg::*;

   state_e         state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [127:0]   acc_q, acc_d;
   logic [64:0]    rem_q, rem_d;
   logic [63:0]    dvsr_q, dvsr_d;
   logic [2:0]     func_q, func_d;
   logic           w_q, w_d;
   logic           nega_q, nega_d;
   logic           negb_q, negb_d;
   logic [63:0]    s_q, s_d;

   logic           sgn_a, sgn_b, a_neg, b_neg;
   logic [63:0]    a_p, b_p, a_mag, b_mag, ovf_min;
   logic           div_zero, div_ovf, special;
   logic [63:0]    spec_raw, spec_res;

   logic [64:0]    step_rem;
   logic           step_q;
   logic [64:0]    mul_sum;
   logic [127:0]   prod;
   logic [63:0]    quo, rmd, raw, fix_res;

   // Operand preparation and special-case detection at acceptance
   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      unique case (func)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
            sgn_a = 1'b1;
            sgn_b = 1'b1;
         end
         MD_MULHSU: sgn_a = 1'b1;
         MD_MULHU, MD_DIVU, MD_REMU: ;
         default: ;
      endcase
      if (sel_32b) begin
         sgn_a = !func[2] || !func[0];
         sgn_b = sgn_a;
      end
      a_p = a;
      b_p = b;
      if (sel_32b) begin
         a_p = {{32{sgn_a & a[31]}}, a[31:0]};
         b_p = {{32{sgn_b & b[31]}}, b[31:0]};
      end
      a_neg   = sgn_a & a_p[63];
      b_neg   = sgn_b & b_p[63];
      a_mag   = a_neg ? -a_p : a_p;
      b_mag   = b_neg ? -b_p : b_p;
      ovf_min = sel_32b ? 64'hFFFF_FFFF_8000_0000
                        : 64'h8000_0000_0000_0000;
      div_zero = (b_p == 64'd0);
      div_ovf  = !func[0] && (a_p == ovf_min) && (b_p == '1);
      special  = func[2] && (div_zero || div_ovf);
      if (func[1])
         spec_raw = div_zero ? a_p : 64'd0;
      else
         spec_raw = div_zero ? '1 : a_p;
      spec_res = sel_32b ? sext32(spec_raw[31:0]) : spec_raw;
   end

   div_step #(.W(64)) u_div_step (
      .rem_i (rem_q),
      .div_i (dvsr_q),
      .bit_i (acc_q[63]),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // Sign correction and result selection
   always_comb begin
      prod = w_q ? (acc_q >> 32) : acc_q;
      if (nega_q ^ negb_q)
         prod = -prod;
      quo = (nega_q ^ negb_q) ? -acc_q[63:0] : acc_q[63:0];
      rmd = nega_q ? -rem_q[63:0] : rem_q[63:0];
      if (func_q[2])
         raw = func_q[1] ? rmd : quo;
      else
         raw = (w_q || func_q == MD_MUL) ? prod[63:0] : prod[127:64];
      fix_res = w_q ? sext32(raw[31:0]) : raw;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      dvsr_d  = dvsr_q;
      func_d  = func_q;
      w_d     = w_q;
      nega_d  = nega_q;
      negb_d  = negb_q;
      s_d     = s_q;
      mul_sum = {1'b0, acc_q[127:64]}
              + (acc_q[0] ? {1'b0, dvsr_q} : 65'd0);
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               func_d = func;
               w_d    = sel_32b;
               nega_d = a_neg;
               negb_d = b_neg;
               dvsr_d = b_mag;
               rem_d  = '0;
               cnt_d  = sel_32b ? 6'(N_32 - 1) : 6'(N_64 - 1);
               if (special)
                  acc_d = {64'd0, spec_res};
               else if (func[2] && sel_32b)
                  acc_d = {64'd0, a_mag[31:0], 32'd0};
               else
                  acc_d = {64'd0, a_mag};
               state_d = special ? ST_SPECIAL : ST_CALC;
            end
         end
         ST_CALC: begin
            if (func_q[2]) begin
               rem_d       = step_rem;
               acc_d[63:0] = {acc_q[62:0], step_q};
            end else begin
               acc_d = {mul_sum, acc_q[63:1]};
            end
            if (cnt_q == 6'd0)
               state_d = ST_FIX;
            else
               cnt_d = cnt_q - 6'd1;
         end
         ST_FIX: begin
            s_d     = fix_res;
            state_d = ST_DONE;
         end
         ST_SPECIAL: begin
            s_d     = acc_q[63:0];
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         dvsr_q  <= '0;
         func_q  <= '0;
         w_q     <= 1'b0;
         nega_q  <= 1'b0;
         negb_q  <= 1'b0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         dvsr_q  <= dvsr_d;
         func_q  <= func_d;
         w_q     <= w_d;
         nega_q  <= nega_d;
         negb_q  <= negb_d;
         s_q     <= s_d;
      end
   end

   assign busy = (state_q == ST_CALC) || (state_q == ST_FIX)
              || (state_q == ST_SPECIAL);
   assign done = (state_q == ST_DONE);
   assign s    = s_q;

endmodule
